// File: rtl/fmdll_lock_ctrl_pkg.sv
// Shared types and constants for the FMDLL lock sequencer.
// Holds the FSM state encoding, clock-mux select values and default code width.
package fmdll_lock_ctrl_pkg;

   localparam int CODE_W_DEF = 10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SAR    = 3'd1,
      ST_TRACK  = 3'd2,
      ST_LOCKED = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

   localparam logic [1:0] SEL_EXT  = 2'b01;
   localparam logic [1:0] SEL_HOLD = 2'b10;

endpackage

// File: rtl/fmdll_settle_timer.sv
// Settle timer: blanks phase-detector samples for SETTLE_CYC cycles after each code write.
// Passes pd_valid through as sample_ok only once the delay line has settled.
module fmdll_settle_timer #(
   parameter int SETTLE_CYC = 4
) (
   input  logic clk_ext,
   input  logic rst_n,
   input  logic load,
   input  logic pd_valid,
   output logic sample_ok
);

   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

   logic [CNT_W-1:0] cnt_reg;

   // load arrives one cycle after the code write, so the load cycle itself is
   // blanked and the counter starts one lower to keep the total at SETTLE_CYC.
   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= LOAD_VAL;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign sample_ok = pd_valid && !load && (cnt_reg == '0);

endmodule

// File: rtl/fmdll_lock_ctrl.sv
// FMDLL lock sequencer: SAR acquisition of the DCDL code, then +/-1 tracking with
// reversal-based lock detection, freeze/hold support and clock-mux select.
module fmdll_lock_ctrl
   import fmdll_lock_ctrl_pkg::*;
#(
   parameter int CODE_W     = CODE_W_DEF,
   parameter int SETTLE_CYC = 4,
   parameter int LOCK_CNT   = 8,
   parameter int UNLOCK_CNT = 3
) (
   input  logic              clk_ext,
   input  logic              rst_n,
   input  logic              en,
   input  logic              freeze,
   input  logic              pd_valid,
   input  logic              pd_lead,
   output logic [CODE_W-1:0] code,
   output logic [1:0]        sel,
   output logic              locked,
   output logic              busy
);

   localparam int PTR_W  = $clog2(CODE_W);
   localparam int REV_W  = $clog2(LOCK_CNT + 1);
   localparam int SAME_W = $clog2(UNLOCK_CNT + 1);
   localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
   localparam logic [CODE_W-1:0] SAR_START = {1'b1, {(CODE_W-1){1'b0}}};

   state_t              state_reg;
   state_t              prev_state_reg;
   logic [CODE_W-1:0]   code_reg;
   logic [PTR_W-1:0]    ptr_reg;
   logic                dir_reg;
   logic                have_dir_reg;
   logic [REV_W-1:0]    rev_cnt_reg;
   logic [SAME_W-1:0]   same_cnt_reg;
   logic                locked_reg;
   logic                busy_reg;
   logic [1:0]          sel_reg;
   logic                settle_load_reg;

   logic                sample_ok;
   logic [CODE_W-1:0]   bit_mask;
   logic [CODE_W-1:0]   sar_code_next;
   logic [CODE_W-1:0]   trk_code_next;
   logic                sat_hit;
   logic [REV_W-1:0]    rev_cnt_next;
   logic [SAME_W-1:0]   same_cnt_next;

   fmdll_settle_timer #(
      .SETTLE_CYC (SETTLE_CYC)
   ) u_settle (
      .clk_ext   (clk_ext),
      .rst_n     (rst_n),
      .load      (settle_load_reg),
      .pd_valid  (pd_valid),
      .sample_ok (sample_ok)
   );

   // One-hot mask of the bit currently being decided by the SAR search.
   genvar gi;
   generate
      for (gi = 0; gi < CODE_W; gi++) begin : g_mask
         assign bit_mask[gi] = (ptr_reg == PTR_W'(gi));
      end
   endgenerate

   always_comb begin
      sar_code_next = pd_lead ? code_reg : (code_reg & ~bit_mask);
      if (ptr_reg != '0) begin
         sar_code_next = sar_code_next | (bit_mask >> 1);
      end

      // A step pushing past either end is clamped but still counts as a step.
      sat_hit = pd_lead ? (code_reg == CODE_MAX) : (code_reg == '0);
      if (sat_hit) begin
         trk_code_next = code_reg;
      end else if (pd_lead) begin
         trk_code_next = code_reg + 1'b1;
      end else begin
         trk_code_next = code_reg - 1'b1;
      end

      rev_cnt_next  = (have_dir_reg && (pd_lead != dir_reg)) ? rev_cnt_reg + 1'b1 : '0;
      same_cnt_next = (have_dir_reg && (pd_lead == dir_reg)) ? same_cnt_reg + 1'b1
                                                             : SAME_W'(1);
   end

   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         prev_state_reg  <= ST_IDLE;
         code_reg        <= '0;
         ptr_reg         <= '0;
         dir_reg         <= 1'b0;
         have_dir_reg    <= 1'b0;
         rev_cnt_reg     <= '0;
         same_cnt_reg    <= '0;
         locked_reg      <= 1'b0;
         busy_reg        <= 1'b0;
         sel_reg         <= SEL_EXT;
         settle_load_reg <= 1'b0;
      end else begin
         settle_load_reg <= 1'b0;
         if (!en) begin
            state_reg    <= ST_IDLE;
            code_reg     <= '0;
            locked_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            sel_reg      <= SEL_EXT;
            rev_cnt_reg  <= '0;
            same_cnt_reg <= '0;
            have_dir_reg <= 1'b0;
         end else begin
            unique case (state_reg)
               ST_IDLE: begin
                  state_reg       <= ST_SAR;
                  code_reg        <= SAR_START;
                  ptr_reg         <= PTR_W'(CODE_W - 1);
                  busy_reg        <= 1'b1;
                  settle_load_reg <= 1'b1;
                  rev_cnt_reg     <= '0;
                  same_cnt_reg    <= '0;
                  have_dir_reg    <= 1'b0;
               end

               ST_SAR: begin
                  if (freeze) begin
                     prev_state_reg <= state_reg;
                     state_reg      <= ST_HOLD;
                     sel_reg        <= SEL_HOLD;
                     busy_reg       <= 1'b0;
                  end else if (sample_ok) begin
                     code_reg        <= sar_code_next;
                     settle_load_reg <= 1'b1;
                     if (ptr_reg != '0) begin
                        ptr_reg <= ptr_reg - 1'b1;
                     end else begin
                        state_reg    <= ST_TRACK;
                        busy_reg     <= 1'b0;
                        have_dir_reg <= 1'b0;
                        rev_cnt_reg  <= '0;
                        same_cnt_reg <= '0;
                     end
                  end
               end

               ST_TRACK: begin
                  if (freeze) begin
                     prev_state_reg <= state_reg;
                     state_reg      <= ST_HOLD;
                     sel_reg        <= SEL_HOLD;
                     busy_reg       <= 1'b0;
                  end else if (sample_ok) begin
                     code_reg        <= trk_code_next;
                     dir_reg         <= pd_lead;
                     have_dir_reg    <= 1'b1;
                     settle_load_reg <= 1'b1;
                     if (rev_cnt_next == REV_W'(LOCK_CNT)) begin
                        locked_reg   <= 1'b1;
                        state_reg    <= ST_LOCKED;
                        rev_cnt_reg  <= '0;
                        // The locking step opens the first same-direction run.
                        same_cnt_reg <= SAME_W'(1);
                     end else begin
                        rev_cnt_reg <= rev_cnt_next;
                     end
                  end
               end

               ST_LOCKED: begin
                  if (freeze) begin
                     prev_state_reg <= state_reg;
                     state_reg      <= ST_HOLD;
                     sel_reg        <= SEL_HOLD;
                     busy_reg       <= 1'b0;
                  end else if (sample_ok) begin
                     code_reg        <= trk_code_next;
                     dir_reg         <= pd_lead;
                     have_dir_reg    <= 1'b1;
                     settle_load_reg <= 1'b1;
                     if (sat_hit || (same_cnt_next == SAME_W'(UNLOCK_CNT))) begin
                        locked_reg   <= 1'b0;
                        state_reg    <= ST_TRACK;
                        rev_cnt_reg  <= '0;
                        same_cnt_reg <= '0;
                     end else begin
                        same_cnt_reg <= same_cnt_next;
                     end
                  end
               end

               ST_HOLD: begin
                  if (!freeze) begin
                     state_reg       <= prev_state_reg;
                     sel_reg         <= SEL_EXT;
                     busy_reg        <= (prev_state_reg == ST_SAR);
                     settle_load_reg <= 1'b1;
                  end
               end

               default: begin
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign code   = code_reg;
   assign sel    = sel_reg;
   assign locked = locked_reg;
   assign busy   = busy_reg;

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// Directed bench for fmdll_lock_ctrl: vector table for SAR/track/lock/unlock,
// then hand sequences for saturation, freeze mid-SAR, en drop and async reset.
module tb_fmdll_lock_ctrl;

   localparam int SETTLE = 4;

   logic       clk_ext = 1'b0;
   logic       rst_n;
   logic       en;
   logic       freeze;
   logic       pd_valid;
   logic       pd_lead;
   logic [9:0] code;
   logic [1:0] sel;
   logic       locked;
   logic       busy;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic       lead;
      logic [9:0] code;
      logic       locked;
      logic       busy;
   } vec_t;

   vec_t vecs [0:21];

   fmdll_lock_ctrl #(
      .CODE_W     (10),
      .SETTLE_CYC (SETTLE),
      .LOCK_CNT   (8),
      .UNLOCK_CNT (3)
   ) dut (
      .clk_ext  (clk_ext),
      .rst_n    (rst_n),
      .en       (en),
      .freeze   (freeze),
      .pd_valid (pd_valid),
      .pd_lead  (pd_lead),
      .code     (code),
      .sel      (sel),
      .locked   (locked),
      .busy     (busy)
   );

   always #5 clk_ext = ~clk_ext;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [9:0] exp_code,
                             input logic [1:0] exp_sel, input logic exp_locked,
                             input logic exp_busy);
      check({name, "_code"},   32'(code),   32'(exp_code));
      check({name, "_sel"},    32'(sel),    32'(exp_sel));
      check({name, "_locked"}, 32'(locked), 32'(exp_locked));
      check({name, "_busy"},   32'(busy),   32'(exp_busy));
   endtask

   // Holding pd_valid for SETTLE+1 cycles right after a code write yields exactly
   // one accepted sample, and the resulting code is visible on return.
   task automatic sample(input logic lead);
      pd_valid = 1'b1;
      pd_lead  = lead;
      repeat (SETTLE + 1) @(negedge clk_ext);
      pd_valid = 1'b0;
   endtask

   initial begin
      // SAR toward 0x15A (lead iff code < 0x15A)
      vecs[0]  = '{1'b0, 10'h100, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 10'h180, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 10'h140, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 10'h160, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 10'h150, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 10'h158, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 10'h15C, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 10'h15A, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 10'h159, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 10'h159, 1'b0, 1'b0};
      // Tracking with alternating direction: 8th reversal on the 9th step
      vecs[10] = '{1'b0, 10'h158, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 10'h159, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 10'h158, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 10'h159, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 10'h158, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 10'h159, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 10'h158, 1'b0, 1'b0};
      vecs[17] = '{1'b1, 10'h159, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 10'h158, 1'b1, 1'b0};
      // Three same-direction steps while locked
      vecs[19] = '{1'b1, 10'h159, 1'b1, 1'b0};
      vecs[20] = '{1'b1, 10'h15A, 1'b1, 1'b0};
      vecs[21] = '{1'b1, 10'h15B, 1'b0, 1'b0};

      rst_n = 1'b0; en = 1'b0; freeze = 1'b0; pd_valid = 1'b0; pd_lead = 1'b0;
      repeat (2) @(negedge clk_ext);
      check_outs("reset", 10'h000, 2'b01, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk_ext);
      check_outs("idle", 10'h000, 2'b01, 1'b0, 1'b0);

      en = 1'b1;
      @(negedge clk_ext);
      check_outs("sar_entry", 10'h200, 2'b01, 1'b0, 1'b1);
      for (int i = 0; i < 22; i++) begin
         sample(vecs[i].lead);
         check_outs($sformatf("vec%0d", i), vecs[i].code, 2'b01, vecs[i].locked, vecs[i].busy);
      end

      // Saturation at the top of the range
      en = 1'b0;
      @(negedge clk_ext);
      check_outs("en_off_track", 10'h000, 2'b01, 1'b0, 1'b0);
      en = 1'b1;
      @(negedge clk_ext);
      for (int i = 0; i < 10; i++) sample(1'b1);
      check_outs("sar_max", 10'h3FF, 2'b01, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         sample(1'b1);
         check_outs($sformatf("sat_track%0d", i), 10'h3FF, 2'b01, 1'b0, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         sample(i[0]);
         check_outs($sformatf("sat_lock%0d", i), i[0] ? 10'h3FF : 10'h3FE, 2'b01,
                    (i == 7), 1'b0);
      end
      sample(1'b1);
      check_outs("sat_unlock", 10'h3FF, 2'b01, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) sample(i[0]);
      check_outs("relock", 10'h3FF, 2'b01, 1'b1, 1'b0);

      // en dropped while locked
      en = 1'b0;
      @(negedge clk_ext);
      check_outs("en_off_locked", 10'h000, 2'b01, 1'b0, 1'b0);

      // Freeze mid-SAR with bit 6 pending and a simultaneous sample
      en = 1'b1;
      @(negedge clk_ext);
      sample(1'b0);
      sample(1'b1);
      sample(1'b0);
      check_outs("pre_freeze", 10'h140, 2'b01, 1'b0, 1'b1);
      pd_valid = 1'b1;
      pd_lead  = 1'b1;
      repeat (SETTLE) @(negedge clk_ext);
      freeze = 1'b1;
      @(negedge clk_ext);
      check_outs("freeze", 10'h140, 2'b10, 1'b0, 1'b0);
      repeat (3) @(negedge clk_ext);
      check_outs("hold", 10'h140, 2'b10, 1'b0, 1'b0);
      freeze = 1'b0;
      @(negedge clk_ext);
      check_outs("release", 10'h140, 2'b01, 1'b0, 1'b1);
      repeat (SETTLE) @(negedge clk_ext);
      check_outs("release_settle", 10'h140, 2'b01, 1'b0, 1'b1);
      @(negedge clk_ext);
      check_outs("resume_bit6", 10'h160, 2'b01, 1'b0, 1'b1);
      pd_valid = 1'b0;

      // Asynchronous reset mid-SAR
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async_reset", 10'h000, 2'b01, 1'b0, 1'b0);
      @(negedge clk_ext);
      rst_n = 1'b1;
      @(negedge clk_ext);
      check_outs("post_reset_sar", 10'h200, 2'b01, 1'b0, 1'b1);
      sample(1'b1);
      check_outs("post_reset_bit9", 10'h300, 2'b01, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
